// File: rtl/zombie_pkg.sv
// Shared types, defaults and helpers for the PunchZombi lane queue core.
package zombie_pkg;

    localparam int unsigned DEF_N_LANES  = 32'd3;
    localparam int unsigned DEF_DEPTH    = 32'd6;
    localparam int unsigned DEF_TIMEOUT  = 32'd50_000_000;
    localparam int unsigned DEF_MAX_MISS = 32'd3;
    localparam int unsigned DEF_SCORE_W  = 32'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PLAY = 2'd2,
        OVER = 2'd3
    } state_t;

    // Random values beyond the last lane wrap back onto the low lanes.
    function automatic int unsigned lane_fold(input int unsigned lane, input int unsigned n_lanes);
        if (lane >= n_lanes) begin
            lane_fold = lane - n_lanes;
        end else begin
            lane_fold = lane;
        end
    endfunction

endpackage

// File: rtl/zombie_lane_queue_if.sv
// Request/valid handshake between the game core and the Random module.
interface zombie_lane_queue_if #(
    parameter int unsigned LW = 32'd2
) ();
    logic          rnd_req;
    logic          rnd_valid;
    logic [LW-1:0] rnd_lane;

    modport master (output rnd_req, input rnd_valid, input rnd_lane);
    modport slave  (input rnd_req, output rnd_valid, output rnd_lane);
endinterface

// File: rtl/zombie_shift_queue.sv
// Front-aligned zombie queue: slot 0 is the hit position, pops shift toward it.
module zombie_shift_queue
    import zombie_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned LW    = 32'd2,
    parameter int unsigned SW    = $clog2(DEPTH),
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [LW-1:0] i_push_lane,
    input  logic [SW-1:0] i_rd_slot,
    output logic [CW-1:0] o_count,
    output logic [LW-1:0] o_front_lane,
    output logic          o_rd_valid,
    output logic [LW-1:0] o_rd_lane
);
    logic [LW-1:0]    r_lane [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;
    logic             w_in_range;
    logic [SW-1:0]    w_wr_idx;

    // A push that coincides with a pop lands one slot lower, keeping entries contiguous.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (w_do_pop || (r_count < CW'(DEPTH)));
    assign w_wr_idx  = w_do_pop ? SW'(r_count - CW'(1)) : SW'(r_count);

    // Storage, valid flags and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) r_lane[i] <= '0;
            r_valid <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < int'(DEPTH); i++) r_lane[i] <= '0;
            r_valid <= '0;
            r_count <= '0;
        end else begin
            if (w_do_pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    r_lane[i]  <= r_lane[i+1];
                    r_valid[i] <= r_valid[i+1];
                end
                r_lane[DEPTH-1]  <= '0;
                r_valid[DEPTH-1] <= 1'b0;
            end
            if (w_do_push) begin
                r_lane[w_wr_idx]  <= i_push_lane;
                r_valid[w_wr_idx] <= 1'b1;
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign w_in_range   = (32'(i_rd_slot) < DEPTH);
    assign o_rd_valid   = w_in_range && r_valid[i_rd_slot];
    assign o_rd_lane    = o_rd_valid ? r_lane[i_rd_slot] : '0;
    assign o_front_lane = r_lane[0];
    assign o_count      = r_count;

endmodule

// File: rtl/zombie_lane_queue.sv
// PunchZombi game core: refills the zombie queue, judges hits/misses/timeouts,
// keeps score and misses, and signals game over.
module zombie_lane_queue
    import zombie_pkg::*;
#(
    parameter int unsigned N_LANES  = DEF_N_LANES,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
    parameter int unsigned MAX_MISS = DEF_MAX_MISS,
    parameter int unsigned SCORE_W  = DEF_SCORE_W,
    parameter int unsigned LW       = $clog2(N_LANES),
    parameter int unsigned SW       = $clog2(DEPTH),
    parameter int unsigned MW       = $clog2(MAX_MISS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_LANES-1:0] btn,
    zombie_lane_queue_if.master rnd,
    input  logic [SW-1:0]      rd_slot,
    output logic               rd_valid,
    output logic [LW-1:0]      rd_lane,
    output logic               shift,
    output logic [SCORE_W-1:0] score,
    output logic [MW-1:0]      misses,
    output logic [1:0]         state,
    output logic               gameover
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 32'd1;

    state_t             r_state, w_state_nx;
    logic [TW-1:0]      r_timer, w_timer_nx, w_timer_inc;
    logic [SCORE_W-1:0] r_score, w_score_nx;
    logic [MW-1:0]      r_misses, w_miss_nx;
    logic               r_rnd_req, r_shift, r_gameover;
    logic               w_push, w_pop, w_clr, w_hit, w_timeout;
    logic [CW-1:0]      w_count, w_count_nx;
    logic [LW-1:0]      w_front_lane, w_push_lane;

    assign w_push      = r_rnd_req && rnd.rnd_valid;
    assign w_push_lane = LW'(lane_fold(32'(rnd.rnd_lane), N_LANES));
    // Exact one-hot match on the front lane; multi-hot never equals a single shifted bit.
    assign w_hit       = (btn == (N_LANES'(1'b1) << w_front_lane));
    assign w_timeout   = (r_timer == TW'(TIMEOUT - 32'd1));
    assign w_timer_inc = w_timeout ? '0 : r_timer + TW'(1'b1);
    assign w_count_nx  = w_clr ? '0 : (w_count + CW'(w_push) - CW'(w_pop));

    zombie_shift_queue #(
        .DEPTH (DEPTH),
        .LW    (LW),
        .SW    (SW),
        .CW    (CW)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_clr),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_push_lane  (w_push_lane),
        .i_rd_slot    (rd_slot),
        .o_count      (w_count),
        .o_front_lane (w_front_lane),
        .o_rd_valid   (rd_valid),
        .o_rd_lane    (rd_lane)
    );

    // Next state, per-cycle judgement and counter updates.
    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_score_nx = r_score;
        w_miss_nx  = r_misses;
        w_pop      = 1'b0;
        w_clr      = 1'b0;
        case (r_state)
            IDLE, OVER: begin
                w_timer_nx = '0;
                if (start) begin
                    w_state_nx = FILL;
                    w_clr      = 1'b1;
                    w_score_nx = '0;
                    w_miss_nx  = '0;
                end else begin
                    w_state_nx = r_state;
                end
            end
            FILL: begin
                w_timer_nx = '0;
                if ((w_count + CW'(w_push)) == CW'(DEPTH)) begin
                    w_state_nx = PLAY;
                end else begin
                    w_state_nx = FILL;
                end
            end
            PLAY: begin
                if (w_count == '0) begin
                    w_timer_nx = '0;
                end else if ((btn == '0) && w_timeout) begin
                    w_pop      = 1'b1;
                    w_timer_nx = '0;
                    w_miss_nx  = r_misses + MW'(1'b1);
                end else if (w_hit) begin
                    w_pop      = 1'b1;
                    w_timer_nx = '0;
                    w_score_nx = (&r_score) ? r_score : r_score + SCORE_W'(1'b1);
                end else if (btn != '0) begin
                    w_miss_nx  = r_misses + MW'(1'b1);
                    w_timer_nx = w_timer_inc;
                end else begin
                    w_timer_nx = w_timer_inc;
                end
                if (w_miss_nx == MW'(MAX_MISS)) begin
                    w_state_nx = OVER;
                    w_clr      = 1'b1;
                end else begin
                    w_state_nx = PLAY;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_clr      = 1'b1;
            end
        endcase
    end

    // State and registered outputs; rnd_req looks at next occupancy so a full queue never over-requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_score    <= '0;
            r_misses   <= '0;
            r_rnd_req  <= 1'b0;
            r_shift    <= 1'b0;
            r_gameover <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_timer    <= w_timer_nx;
            r_score    <= w_score_nx;
            r_misses   <= w_miss_nx;
            r_shift    <= w_pop;
            r_gameover <= (w_state_nx == OVER);
            r_rnd_req  <= ((w_state_nx == FILL) || (w_state_nx == PLAY)) && (w_count_nx < CW'(DEPTH));
        end
    end

    assign rnd.rnd_req = r_rnd_req;
    assign shift       = r_shift;
    assign score       = r_score;
    assign misses      = r_misses;
    assign state       = r_state;
    assign gameover    = r_gameover;

endmodule

// File: tb/tb_zombie_lane_queue.sv
// Scoreboard bench for zombie_lane_queue with N_LANES=3, DEPTH=6, TIMEOUT=8, MAX_MISS=3.
module tb_zombie_lane_queue;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] btn;
    logic [2:0] rd_slot;
    logic       rd_valid;
    logic [1:0] rd_lane;
    logic       shift;
    logic [9:0] score;
    logic [1:0] misses;
    logic [1:0] state;
    logic       gameover;

    int n_checks = 0;
    int n_errs   = 0;
    int sb[$];

    zombie_lane_queue_if #(.LW(2)) rnd_if ();

    zombie_lane_queue #(
        .N_LANES (3), .DEPTH (6), .TIMEOUT (8), .MAX_MISS (3), .SCORE_W (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .btn      (btn),
        .rnd      (rnd_if),
        .rd_slot  (rd_slot),
        .rd_valid (rd_valid),
        .rd_lane  (rd_lane),
        .shift    (shift),
        .score    (score),
        .misses   (misses),
        .state    (state),
        .gameover (gameover)
    );

    always #10 clk = ~clk;

    task automatic chk_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s got=%0d want=%0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int fold(input int l);
        return (l >= 3) ? l - 3 : l;
    endfunction

    // Sweep the display port (including out-of-range slots) against the scoreboard.
    task automatic chk_slots(input string tag);
        for (int s = 0; s < 8; s++) begin
            rd_slot = 3'(s);
            #1;
            chk_val({tag, "_valid"}, int'(rd_valid), (s < sb.size()) ? 1 : 0);
            chk_val({tag, "_lane"}, int'(rd_lane), (s < sb.size()) ? sb[s] : 0);
        end
    endtask

    task automatic chk_status(input string tag, input int st, input int sc, input int ms,
                              input int sh, input int rq, input int go);
        chk_val({tag, "_state"}, int'(state), st);
        chk_val({tag, "_score"}, int'(score), sc);
        chk_val({tag, "_misses"}, int'(misses), ms);
        chk_val({tag, "_shift"}, int'(shift), sh);
        chk_val({tag, "_req"}, int'(rnd_if.rnd_req), rq);
        chk_val({tag, "_gameover"}, int'(gameover), go);
    endtask

    initial begin
        int fill_lanes[6];
        int lane;
        fill_lanes = '{0, 1, 2, 3, 0, 1};
        rst = 1'b0; start = 1'b0; btn = 3'b000; rd_slot = 3'd0;
        rnd_if.rnd_valid = 1'b0; rnd_if.rnd_lane = 2'd0;
        #25;
        chk_status("reset", 0, 0, 0, 0, 0, 0);
        chk_slots("reset");
        rst = 1'b1;
        tick();
        chk_val("idle_hold", int'(state), 0);

        // Fill with the folded lane sequence; a stray button in FILL must be ignored.
        start = 1'b1; tick(); start = 1'b0;
        chk_status("fill_entry", 1, 0, 0, 0, 1, 0);
        rnd_if.rnd_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rnd_if.rnd_lane = 2'(fill_lanes[k]);
            btn = (k == 2) ? 3'b001 : 3'b000;
            tick();
            sb.push_back(fold(fill_lanes[k]));
            if (k < 5) chk_val("fill_state", int'(state), 1);
        end
        rnd_if.rnd_valid = 1'b0; btn = 3'b000;
        chk_status("fill_done", 2, 0, 0, 0, 0, 0);
        chk_slots("fill");

        // Hit on the front lane, then one refill transfer.
        btn = 3'b001 << sb[0]; tick(); btn = 3'b000;
        void'(sb.pop_front());
        chk_status("hit", 2, 1, 0, 1, 1, 0);
        chk_slots("hit");
        rnd_if.rnd_valid = 1'b1; rnd_if.rnd_lane = 2'd2; tick(); rnd_if.rnd_valid = 1'b0;
        sb.push_back(2);
        chk_status("refill", 2, 1, 0, 0, 0, 0);
        chk_slots("refill");

        // Correct press on the 8th cycle after the pop beats the timeout.
        repeat (6) tick();
        chk_status("pre_timeout", 2, 1, 0, 0, 0, 0);
        btn = 3'b001 << sb[0]; tick(); btn = 3'b000;
        void'(sb.pop_front());
        chk_status("late_hit", 2, 2, 0, 1, 1, 0);
        rnd_if.rnd_valid = 1'b1; rnd_if.rnd_lane = 2'd0; tick(); rnd_if.rnd_valid = 1'b0;
        sb.push_back(0);

        // No press: cycle 7 is quiet, cycle 8 times out.
        repeat (6) tick();
        chk_status("timeout_edge", 2, 2, 0, 0, 0, 0);
        tick();
        void'(sb.pop_front());
        chk_status("timeout", 2, 2, 1, 1, 1, 0);
        chk_slots("timeout");
        rnd_if.rnd_valid = 1'b1; rnd_if.rnd_lane = 2'd3; tick(); rnd_if.rnd_valid = 1'b0;
        sb.push_back(fold(3));
        chk_slots("refill2");

        // Wrong single lane, then multi-hot ends the game.
        btn = 3'b001 << ((sb[0] + 1) % 3); tick(); btn = 3'b000;
        chk_status("wrong", 2, 2, 2, 0, 0, 0);
        chk_slots("wrong");
        btn = 3'b011; tick(); btn = 3'b000;
        sb.delete();
        chk_status("over", 3, 2, 3, 0, 0, 1);
        chk_slots("over");
        btn = 3'b111; tick(); btn = 3'b000;
        chk_status("over_frozen", 3, 2, 3, 0, 0, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk_status("restart", 1, 0, 0, 0, 1, 0);
        chk_slots("restart");

        // Second game: random lanes, then hits with simultaneous refill transfers.
        rnd_if.rnd_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            lane = int'($urandom_range(0, 3));
            rnd_if.rnd_lane = 2'(lane);
            tick();
            sb.push_back(fold(lane));
        end
        rnd_if.rnd_valid = 1'b0;
        chk_status("fill2", 2, 0, 0, 0, 0, 0);
        chk_slots("fill2");
        for (int h = 0; h < 5; h++) begin
            lane = int'($urandom_range(0, 3));
            btn = 3'b001 << sb[0];
            rnd_if.rnd_valid = (h > 0);
            rnd_if.rnd_lane = 2'(lane);
            tick();
            btn = 3'b000; rnd_if.rnd_valid = 1'b0;
            void'(sb.pop_front());
            if (h > 0) sb.push_back(fold(lane));
            chk_status("hit_loop", 2, h + 1, 0, 1, 1, 0);
            chk_slots("hit_loop");
        end

        // Asynchronous reset between clock edges.
        #3;
        rst = 1'b0;
        #1;
        sb.delete();
        chk_status("async_reset", 0, 0, 0, 0, 0, 0);
        chk_slots("async_reset");
        #15;
        rst = 1'b1;
        tick();
        tick();
        chk_status("post_reset", 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
